// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word-addressed memory slave with pipelined address/data phases,
// read-after-write forwarding and programmable wait states on the first beat of a burst.
//
// state    | meaning
// S_IDLE   | no burst in progress, Ready high
// S_WAIT   | first-beat wait states, Ready low, wait counter running
// S_ACTIVE | burst streaming one beat per cycle, Ready high
module bus_mem_slave #(
    parameter logic [1:0] SLAVE_ID    = 2'b00,
    parameter int         ADDR_WIDTH  = 10,
    parameter int         WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  Control,
    input  logic [31:0] Address,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Ready
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] ST_START  = 2'b00;
    localparam logic [1:0] ST_CONT   = 2'b01;
    localparam logic [1:0] SZ_B      = 2'b00;
    localparam logic [1:0] SZ_HW     = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_ACTIVE = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic [1:0]            status;
    logic [1:0]            size;
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  sel;
    logic                  is_start;
    logic                  accept;

    logic                  dp_valid;
    logic                  dp_we;
    logic [1:0]            dp_size;
    logic [ADDR_WIDTH-1:0] dp_addr;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] wr_mask;
    logic [31:0] wr_word;
    logic        mem_we;
    logic        fwd_hit;
    logic [31:0] rd_word;

    logic unused_bits;

    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    lane_mask = 32'h0000_00FF;
            SZ_HW:   lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign status   = Control[8:7];
    assign size     = Control[2:1];
    assign we       = Control[0];
    assign rd_addr  = Address[ADDR_WIDTH-1:0];
    assign sel      = (Address[31:30] == SLAVE_ID);
    assign is_start = (status == ST_START);

    // burst code and the non-select upper address bits carry no meaning here
    assign unused_bits = ^{Control[6:3], Address[29:ADDR_WIDTH]};

    assign Ready  = (state != S_WAIT);
    assign accept = Ready && sel && (is_start || (status == ST_CONT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_ACTIVE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            default: begin
                if (accept && is_start && (WAIT_STATES > 0)) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = WAIT_LOAD;
                end else if (accept) begin
                    state_nxt = S_ACTIVE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // write lanes come from WData, the rest from the stored word
    assign wr_mask = lane_mask(dp_size);
    assign wr_word = (mem[dp_addr] & ~wr_mask) | (WData & wr_mask);
    assign mem_we  = dp_valid && dp_we && Ready;

    // a read landing on the edge its own word is being written sees the new value
    assign fwd_hit = mem_we && (dp_addr == rd_addr);
    assign rd_word = fwd_hit ? wr_word : mem[rd_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[dp_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_valid <= 1'b0;
            dp_we    <= 1'b0;
            dp_size  <= 2'b00;
            dp_addr  <= '0;
            RData    <= 32'h0;
        end else if (Ready) begin
            dp_valid <= accept;
            if (accept) begin
                dp_we   <= we;
                dp_size <= size;
                dp_addr <= rd_addr;
                if (!we) begin
                    RData <= rd_word & lane_mask(size);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: a pipelined master pushes expected read data,
// a monitor pops and compares whenever a read data phase is completing.
module tb_bus_mem_slave;

    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] CONT  = 2'b01;
    localparam logic [1:0] IDLE  = 2'b10;
    localparam logic [1:0] B     = 2'b00;
    localparam logic [1:0] HW    = 2'b01;
    localparam logic [1:0] W     = 2'b10;
    localparam logic [8:0] CTRL_IDLE = {IDLE, 4'b0000, 2'b10, 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic        use0;
    logic [8:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [8:0]  ctrl_m, ctrl_z;
    logic [31:0] rdata_m, rdata_z;
    logic        ready_m, ready_z;
    logic        rdy;
    logic [31:0] rd;

    logic [31:0] exp_q[$];
    logic [31:0] pend_wd;
    logic        rd_issue;
    logic        rd_dp;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          s;

    always #5 clk = ~clk;

    assign ctrl_m = use0 ? CTRL_IDLE : ctrl;
    assign ctrl_z = use0 ? ctrl : CTRL_IDLE;
    assign rdy    = use0 ? ready_z : ready_m;
    assign rd     = use0 ? rdata_z : rdata_m;

    bus_mem_slave #(.SLAVE_ID(2'b00), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .Control(ctrl_m), .Address(addr),
        .WData(wdata), .RData(rdata_m), .Ready(ready_m)
    );

    bus_mem_slave #(.SLAVE_ID(2'b00), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .Control(ctrl_z), .Address(addr),
        .WData(wdata), .RData(rdata_z), .Ready(ready_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // tracks whether the data phase currently pending is a selected read
    always @(posedge clk or posedge reset) begin
        if (reset) rd_dp <= 1'b0;
        else if (rdy) rd_dp <= rd_issue;
    end

    always @(negedge clk) begin
        if (!reset && rd_dp && rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata_unexpected: got 0x%08h with no read expected", rd);
            end else begin
                check("rdata", rd, exp_q.pop_front());
                n_pop++;
            end
        end
    end

    // called on a negedge; drives one address phase plus the previous beat's write data,
    // returns after the accepting edge with the number of stalled cycles seen
    task automatic beat(input logic [1:0] st, input logic w_en, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output int stalls);
        ctrl     = {st, 4'b0000, sz, w_en};
        addr     = a;
        wdata    = pend_wd;
        pend_wd  = w_en ? d : 32'h0;
        rd_issue = !w_en && (a[31:30] == 2'b00) && (st == START || st == CONT);
        if (rd_issue) begin
            exp_q.push_back(d);
            n_push++;
        end
        stalls = 0;
        while (!rdy && stalls < 40) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: Ready stuck low for %0d cycles, required high", stalls);
        end
        @(negedge clk);
    endtask

    task automatic idle(output int stalls);
        beat(IDLE, 1'b0, W, 32'h0, 32'h0, stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        use0     = 1'b0;
        ctrl     = CTRL_IDLE;
        addr     = 32'h0;
        wdata    = 32'h0;
        pend_wd  = 32'h0;
        rd_issue = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_ready", {31'h0, ready_m}, 32'h1);
        check("reset_rdata", rdata_m, 32'h0);
        check("reset_ready_ws0", {31'h0, ready_z}, 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // single START write with two wait states, then read back
        beat(START, 1'b1, W, 32'h005, 32'hDEADBEEF, s);
        check("t1_start_stall", 32'(s), 32'd0);
        idle(s);
        check("t1_wait_cycles", 32'(s), 32'd2);
        idle(s);
        check("t1_ready_back", 32'(s), 32'd0);
        beat(START, 1'b0, W, 32'h005, 32'hDEADBEEF, s);
        idle(s);
        check("t1_read_wait", 32'(s), 32'd2);

        // four-beat write burst then four-beat read burst; waits on the first beat only
        for (int i = 0; i < 4; i++) begin
            beat((i == 0) ? START : CONT, 1'b1, W, 32'h010 + 32'(i), 32'hA000_0010 + 32'(i), s);
            check("t2_wr_stall", 32'(s), (i == 1) ? 32'd2 : 32'd0);
        end
        idle(s);
        check("t2_wr_tail", 32'(s), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat((i == 0) ? START : CONT, 1'b0, W, 32'h010 + 32'(i), 32'hA000_0010 + 32'(i), s);
            check("t2_rd_stall", 32'(s), (i == 1) ? 32'd2 : 32'd0);
        end
        idle(s);

        // byte write masking and sized reads
        beat(START, 1'b1, W, 32'h020, 32'hAABBCCDD, s);
        idle(s);
        beat(START, 1'b1, B, 32'h020, 32'h0000_0011, s);
        idle(s);
        beat(START, 1'b0, W,  32'h020, 32'hAABBCC11, s);
        beat(CONT,  1'b0, B,  32'h020, 32'h0000_0011, s);
        beat(CONT,  1'b0, HW, 32'h020, 32'h0000_CC11, s);
        idle(s);

        // zero-wait instance: back-to-back write/read forwarding and merged-lane forwarding
        use0 = 1'b1;
        beat(START, 1'b1, W, 32'h030, 32'h1111_1111, s);
        idle(s);
        beat(START, 1'b1, W, 32'h030, 32'h0BADF00D, s);
        beat(START, 1'b0, W, 32'h030, 32'h0BADF00D, s);
        check("t4_no_wait", 32'(s), 32'd0);
        idle(s);
        beat(START, 1'b1, W, 32'h031, 32'h1234_5678, s);
        beat(CONT,  1'b1, B, 32'h031, 32'h0000_00AB, s);
        beat(CONT,  1'b0, W, 32'h031, 32'h1234_56AB, s);
        idle(s);
        idle(s);
        use0 = 1'b0;

        // not-selected beats must leave memory, Ready and RData alone
        beat(START, 1'b1, W, 32'h040, 32'h55AA55AA, s);
        idle(s);
        beat(START, 1'b0, W, 32'h040, 32'h55AA55AA, s);
        idle(s);
        beat(START, 1'b1, W, 32'h4000_0040, 32'h0000_1234, s);
        check("t5_nosel_stall", 32'(s), 32'd0);
        idle(s);
        check("t5_nosel_ready", 32'(s), 32'd0);
        check("t5_rdata_hold", rdata_m, 32'h55AA55AA);
        beat(START, 1'b0, W, 32'hC000_0005, 32'h0, s);
        idle(s);
        check("t5_nosel_read_hold", rdata_m, 32'h55AA55AA);
        beat(START, 1'b0, W, 32'h040, 32'h55AA55AA, s);
        idle(s);
        // upper non-select address bits are ignored: 0x405 aliases word 0x005
        beat(START, 1'b0, W, 32'h0000_0405, 32'hDEADBEEF, s);
        idle(s);

        // reset in the middle of a START write's wait states
        beat(START, 1'b1, W, 32'h050, 32'hCAFEF00D, s);
        idle(s);
        beat(START, 1'b0, W, 32'h050, 32'hCAFEF00D, s);
        idle(s);
        ctrl     = {START, 4'b0000, W, 1'b1};
        addr     = 32'h050;
        wdata    = 32'h0;
        rd_issue = 1'b0;
        @(negedge clk);
        wdata = 32'hFFFF_FFFF;
        check("t6_in_wait", {31'h0, ready_m}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("t6_reset_ready", {31'h0, ready_m}, 32'h1);
        check("t6_reset_rdata", rdata_m, 32'h0);
        @(negedge clk);
        ctrl    = CTRL_IDLE;
        pend_wd = 32'h0;
        reset   = 1'b0;
        beat(START, 1'b0, W, 32'h050, 32'hCAFEF00D, s);
        idle(s);
        idle(s);

        check("reads_completed", 32'(n_pop), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
